// File: rtl/lut_mult_pkg.sv
// Shared types and widths for the arbitrated constant multiplier.
// Stage records carry the widest legal ID; users slice down to their own ID width.
package lut_mult_pkg;

    localparam int PROD_W   = 16;
    localparam int X_W      = 8;
    localparam int MAX_ID_W = 4;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic [X_W-1:0]      x;
    } stage_t;

endpackage

// File: rtl/lut_mult_8bit.sv
// Combinational 8-bit by constant multiplier built from a 16-entry nibble table.
// The two nibble products are recombined with a 4-bit shift.
module lut_mult_8bit #(
    parameter int A_const = 2
) (
    input  logic [7:0]  x_i,
    output logic [15:0] c_o
);

    // 15 * 255 = 3825 fits comfortably in 12 bits.
    logic [11:0] nib_lut [16];

    for (genvar i = 0; i < 16; i++) begin : g_lut
        assign nib_lut[i] = 12'(i * A_const);
    end

    assign c_o = ({4'b0, nib_lut[x_i[7:4]]} << 4) + {4'b0, nib_lut[x_i[3:0]]};

endmodule

// File: rtl/lut_mult_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
// The pointer register lives in the caller.
module rr_arbiter
    import lut_mult_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    always_comb begin
        int   idx;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Explicit modulo keeps the wrap correct for non-power-of-two NUM_REQ.
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt[idx] = en;
            end
        end
    end

endmodule

// File: rtl/lut_mult_arbiter.sv
// Round-robin sharing of one constant multiplier across NUM_REQ lanes through a
// two-stage pipe (issue register, output register) with full backpressure.
module lut_mult_arbiter
    import lut_mult_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int A_const = 2,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_x,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [PROD_W-1:0]    rsp_c
);

    stage_t              s1_q, s1_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [PROD_W-1:0]   rsp_c_q, rsp_c_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                s2_load;
    logic                s1_can;
    logic                accept;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    logic [PROD_W-1:0]   prod;

    assign s2_load = !rsp_valid_q || rsp_ready;
    assign s1_can  = !s1_q.valid || s2_load;
    assign accept  = |gnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (s1_can && !rst),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    lut_mult_8bit #(.A_const(A_const)) u_mult (
        .x_i (s1_q.x),
        .c_o (prod)
    );

    always_comb begin
        s1_d        = s1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        rr_ptr_d    = rr_ptr_q;

        // Output payload only moves when real data arrives, so a stall holds it.
        if (s2_load) begin
            rsp_valid_d = s1_q.valid;
            if (s1_q.valid) begin
                rsp_id_d = s1_q.id[ID_W-1:0];
                rsp_c_d  = prod;
            end
        end

        if (accept) begin
            s1_d.valid = 1'b1;
            s1_d.id    = MAX_ID_W'(gnt_id);
            s1_d.x     = req_x[gnt_id*8 +: 8];
            rr_ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (s2_load) begin
            s1_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_c_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            s1_q        <= s1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;

endmodule

// File: doc/lut_mult_arbiter.md
# lut_mult_arbiter

Shares one combinational 8-bit constant multiplier (`lut_mult_8bit`) between `NUM_REQ` requesters. Each requester has a valid/ready handshake. Arbitration is round-robin, and the shared multiplier is wrapped in a two-stage registered pipeline with full backpressure. Each response carries the product and the ID of the requester that issued it. The block sits between the requesting datapath lanes and the single multiplier instance, so the LUT hardware is not replicated per lane.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `A_const`, 2: constant multiplicand forwarded to the multiplier, 0..255.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID (derived, not overridden).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_x`  in  NUM_REQ*8  packed operands; requester i occupies bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `rsp_valid`  out  1  product valid.
- `rsp_ready`  in  1  downstream accept.
- `rsp_id`  out  ID_W  index of the requester that produced this product.
- `rsp_c`  out  16  product X*A_const.

## Operation
- **Handshakes:** a transfer occurs when valid and ready are both high on a rising edge. This holds for each request lane and for the response port.
- **Stage 1 (issue register):** holds `s1_valid`, `s1_x`, `s1_id`. The multiplier takes `s1_x` combinationally.
- **Stage 2 (output register):** holds `rsp_valid`, `rsp_id`, `rsp_c`. It captures the stage-1 contents and the multiplier output.
- **Advance rules:**
  - Stage 2 loads when it is empty, or when `rsp_valid && rsp_ready`.
  - Stage 1 may accept a new request when it is empty, or when it advances into stage 2 in the same cycle.
- **Arbitration:**
  - A round-robin pointer `rr_ptr` names the highest-priority index.
  - The grant goes to the first valid requester, searching from `rr_ptr` upward with wrap at `NUM_REQ-1 → 0`.
  - `req_ready[g]` is high only for the granted index g, and only when stage 1 can accept. All other `req_ready` bits are 0.
  - `req_ready` may depend combinationally on `req_valid`.
- **Pointer update:** on an accepted transfer from g, `rr_ptr <= (g+1) mod NUM_REQ`. With no transfer, `rr_ptr` holds.
- **Ordering:** responses leave in acceptance order. No request is dropped or duplicated.
- **Arithmetic:** `rsp_c` = `req_x * A_const`, exact. The maximum 255*255 = 65025 fits in 16 bits.
- **Stall:** while `rsp_valid && !rsp_ready`, `rsp_id` and `rsp_c` hold stable.
- **Simultaneous drain and issue:** these are allowed in one cycle, giving a sustained throughput of 1 product per cycle.

## Timing
- **Reset values** (asynchronous, take effect immediately on `rst` high):
  - `rsp_valid`=0, `rsp_id`=0, `rsp_c`=0.
  - `s1_valid`=0, `rr_ptr`=0.
  - `req_ready`=0 while `rst` is high.
- **Reset mid-operation:** all in-flight operations are discarded. No response is emitted for them after `rst` deasserts.
- **Latency:** a request accepted at edge t gives `rsp_valid`=1 after edge t+1, provided stage 2 is free. That is 2 edges from acceptance to the output being presented.
- **Capacity:** at most 2 operations are in flight. If `rsp_ready`=0 persists, the pipe fills, and all `req_ready` are 0 from the cycle both stages are full.
- **Boundary cases:**
  - `NUM_REQ` not a power of two: the wrap uses explicit modulo, and IDs ≥ `NUM_REQ` never appear.
  - Single valid requester: it is granted every cycle the pipe accepts.

## Structure
- **Shared package `lut_mult_pkg`:**
  - `ID_W` derivation function.
  - Stage record typedef {valid, id, x}.
  - Product width constant (16).
- **Sub-module `rr_arbiter`:**
  - Parameter `NUM_REQ`.
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and encoded `gnt_id`.
  - Purely combinational; the pointer register stays in the top level.
- **Multiplier:** the existing `lut_mult_8bit` is instantiated once, with `A_const` passed through.

## Test plan
- **Single request:** req 0 valid, x=100, `rsp_ready`=1 → accepted at edge t; at t+1 `rsp_valid`=1, `rsp_id`=0, `rsp_c`=200.
- **All requesters at once:** `req_valid`=4'b1111, x={4,3,2,1} for ids 3..0 → grants 0,1,2,3 on consecutive edges; responses c=2,4,6,8 with ids 0..3, one per cycle.
- **Fairness:** req 0 and req 2 continuously valid, `rsp_ready`=1 → grant sequence 0,2,0,2,…; req 1 and req 3 `req_ready` never high.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with reqs 0 and 1 pending:
  - exactly 2 accepts occur, then `req_ready`=0;
  - `rsp_id` and `rsp_c` stay stable throughout;
  - after release, products arrive in order with no loss or duplication.
- **Reset mid-operation:** assert `rst` with both stages full → `rsp_valid`=0 immediately and no stale response afterwards; first post-reset grant goes to the lowest valid index (`rr_ptr`=0).
- **Boundary product:** `A_const`=255, x=255 → `rsp_c`=65025; x=0 → `rsp_c`=0.
